// File: rtl/oam_line_scanner.sv
// Per-line sprite selection: walks the object attribute RAM at each line start and keeps the first
// MAX_SPRITES objects covering the line. Optional X-ordered insertion under macro OAM_SCAN_SORT_EN.
module oam_line_scanner #(
  parameter int unsigned NUM_OBJ     = 40,
  parameter int unsigned MAX_SPRITES = 10,
  parameter int unsigned STEP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ly,
  input  logic        obj_tall,
  output logic [6:0]  oam_adb,
  output logic        oam_ceb,
  output logic        oam_oce,
  input  logic [15:0] oam_dout,
  output logic        busy,
  output logic        done,
  output logic [3:0]  count,
  input  logic [3:0]  rd_slot,
  output logic [5:0]  rd_idx,
  output logic [7:0]  rd_x
);

  localparam int unsigned OBJ_W = 6;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PH_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int          NSLOT = int'(MAX_SPRITES);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  typedef struct packed {
    logic [OBJ_W-1:0] idx;
    logic [7:0]       x;
  } entry_t;

  state_t           state_q, state_d;
  logic [OBJ_W-1:0] obj_q, obj_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [7:0]       ly_q, ly_d;
  logic             tall_q, tall_d;
  logic             valid_q, valid_d;
  logic [OBJ_W-1:0] rd_obj_q, rd_obj_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           entry_q [MAX_SPRITES];
  entry_t           entry_d [MAX_SPRITES];

  logic             issue_c, start_acc_c, scan_end_c, hit_c;
  logic [8:0]       dist_c, lim_c;
  entry_t           new_c;
`ifdef OAM_SCAN_SORT_EN
  logic [CNT_W-1:0] ins_c;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: the edge that issues the last object moves to DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (phase_q == '0 && obj_q == OBJ_W'(NUM_OBJ - 1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State decode
  always_comb begin
    issue_c     = (state_q == S_SCAN) && (phase_q == '0);
    start_acc_c = (state_q == S_IDLE) && start;
    scan_end_c  = (state_q == S_DRAIN);
  end

  assign oam_ceb = issue_c;
  assign oam_adb = {obj_q, 1'b0};
  assign oam_oce = 1'b1;

  // Row coverage: distance from the sprite top (Y is biased by 16) wraps on underflow
  assign dist_c = {1'b0, ly_q} + 9'd16 - {1'b0, oam_dout[7:0]};
  assign lim_c  = tall_q ? 9'd16 : 9'd8;
  assign hit_c  = valid_q && (dist_c < lim_c);
  assign new_c  = {rd_obj_q, oam_dout[15:8]};

  always_comb begin
    obj_d    = obj_q;
    phase_d  = phase_q;
    ly_d     = ly_q;
    tall_d   = tall_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    count_d  = count_q;
    valid_d  = issue_c;
    rd_obj_d = issue_c ? obj_q : rd_obj_q;
    entry_d  = entry_q;
`ifdef OAM_SCAN_SORT_EN
    ins_c    = '0;
`endif
    if (start_acc_c) begin
      busy_d  = 1'b1;
      count_d = '0;
      obj_d   = '0;
      phase_d = '0;
      ly_d    = ly;
      tall_d  = obj_tall;
    end
    if (state_q == S_SCAN) begin
      if (phase_q == PH_W'(STEP_CYCLES - 1)) begin
        phase_d = '0;
        obj_d   = obj_q + OBJ_W'(1);
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
    if (scan_end_c) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (hit_c && (count_q < CNT_W'(MAX_SPRITES))) begin
`ifdef OAM_SCAN_SORT_EN
      // Slot after the last entry with X <= new X keeps ties in OAM order
      for (int j = 0; j < NSLOT; j++)
        if (CNT_W'(j) < count_q && entry_q[j].x <= new_c.x) ins_c = ins_c + CNT_W'(1);
      for (int j = 1; j < NSLOT; j++)
        if (CNT_W'(j) > ins_c && CNT_W'(j) <= count_q) entry_d[j] = entry_q[j-1];
      for (int j = 0; j < NSLOT; j++)
        if (CNT_W'(j) == ins_c) entry_d[j] = new_c;
`else
      for (int j = 0; j < NSLOT; j++)
        if (CNT_W'(j) == count_q) entry_d[j] = new_c;
`endif
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obj_q    <= '0;
      phase_q  <= '0;
      ly_q     <= '0;
      tall_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_obj_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      for (int j = 0; j < NSLOT; j++) entry_q[j] <= '0;
    end else begin
      obj_q    <= obj_d;
      phase_q  <= phase_d;
      ly_q     <= ly_d;
      tall_q   <= tall_d;
      valid_q  <= valid_d;
      rd_obj_q <= rd_obj_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
      for (int j = 0; j < NSLOT; j++) entry_q[j] <= entry_d[j];
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

  // Slot query; slots at or beyond count read as zero
  always_comb begin
    rd_idx = '0;
    rd_x   = '0;
    for (int j = 0; j < NSLOT; j++) begin
      if (CNT_W'(j) == rd_slot && rd_slot < count_q) begin
        rd_idx = entry_q[j].idx;
        rd_x   = entry_q[j].x;
      end
    end
  end

endmodule

// File: tb/tb_oam_line_scanner.sv
// Bench for oam_line_scanner: directed cases plus randomized lines against a list-based selection model.
module tb_oam_line_scanner;

  localparam int NOBJ = 40;
  localparam int NSPR = 10;
  localparam int SCAN_LAT = 81;

  logic        clk, reset, start, tall_i;
  logic [7:0]  ly_i;
  logic [6:0]  oam_adb;
  logic        oam_ceb, oam_oce;
  logic [15:0] oam_dout;
  logic        busy, done;
  logic [3:0]  count, rd_slot;
  logic [5:0]  rd_idx;
  logic [7:0]  rd_x;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [128];
  logic [7:0]  obj_x [NOBJ];
  logic [7:0]  obj_y [NOBJ];
  int exp_idx[$];
  int exp_x[$];

  oam_line_scanner dut (
    .clk(clk), .reset(reset), .start(start), .ly(ly_i), .obj_tall(tall_i),
    .oam_adb(oam_adb), .oam_ceb(oam_ceb), .oam_oce(oam_oce), .oam_dout(oam_dout),
    .busy(busy), .done(done), .count(count),
    .rd_slot(rd_slot), .rd_idx(rd_idx), .rd_x(rd_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bypass-mode RAM read port
  always @(posedge clk) if (oam_ceb) oam_dout <= ram[oam_adb];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] y);
    for (int i = 0; i < NOBJ; i++) begin
      obj_y[i] = y;
      obj_x[i] = 8'($urandom);
    end
  endtask

  task automatic load_ram();
    for (int i = 0; i < NOBJ; i++) begin
      ram[2*i]   = {obj_x[i], obj_y[i]};
      ram[2*i+1] = 16'($urandom);
    end
  endtask

  // First NSPR objects covering the line, in OAM order (stably X-sorted when the sort build is on)
  task automatic model(input logic [7:0] l, input logic t);
    int d, lim, j, kx, ki;
    exp_idx.delete();
    exp_x.delete();
    lim = t ? 16 : 8;
    for (int i = 0; i < NOBJ; i++) begin
      d = (int'(l) + 16 - int'(obj_y[i]) + 512) % 512;
      if (d < lim && exp_idx.size() < NSPR) begin
        exp_idx.push_back(i);
        exp_x.push_back(int'(obj_x[i]));
      end
    end
`ifdef OAM_SCAN_SORT_EN
    for (int i = 1; i < exp_x.size(); i++) begin
      kx = exp_x[i];
      ki = exp_idx[i];
      j = i - 1;
      while (j >= 0 && exp_x[j] > kx) begin
        exp_x[j+1] = exp_x[j];
        exp_idx[j+1] = exp_idx[j];
        j--;
      end
      exp_x[j+1] = kx;
      exp_idx[j+1] = ki;
    end
`endif
  endtask

  task automatic check_results(input string tag);
    int ei, ex;
    check({tag, "_count"}, 32'(count), 32'(exp_idx.size()));
    for (int s = 0; s < 16; s++) begin
      if (s > 11 && s != 15) continue;
      rd_slot = 4'(s);
      #1;
      ei = (s < exp_idx.size()) ? exp_idx[s] : 0;
      ex = (s < exp_x.size()) ? exp_x[s] : 0;
      check($sformatf("%s_idx%0d", tag, s), 32'(rd_idx), 32'(ei));
      check($sformatf("%s_x%0d", tag, s), 32'(rd_x), 32'(ex));
    end
    rd_slot = 4'd0;
  endtask

  // Pulse start now; returns clocks from start cycle to done cycle (-1 on timeout)
  task automatic run_scan(input logic [7:0] l, input logic t, output int lat);
    ly_i = l;
    tall_i = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ly_i = 8'($urandom);
    tall_i = 1'($urandom);
    check("busy_at_start", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic setup_t1();
    set_all(8'd0);
    obj_y[0] = 8'd16; obj_x[0] = 8'd8;
    obj_y[5] = 8'd9;  obj_x[5] = 8'd20;
    load_ram();
  endtask

  initial begin
    int lat, n;
    logic seen;
    logic [7:0] l, l2;
    logic t, t2;
    reset = 1'b1; start = 1'b0; ly_i = '0; tall_i = 1'b0; rd_slot = '0;
    set_all(8'd0);
    load_ram();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ceb", 32'(oam_ceb), 32'd0);
    check("oce", 32'(oam_oce), 32'd1);
    check("rst_rd_idx", 32'(rd_idx), 32'd0);
    check("rst_rd_x", 32'(rd_x), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Two hits on line 0, 8-row
    setup_t1();
    model(8'd0, 1'b0);
    run_scan(8'd0, 1'b0, lat);
    check("t1_lat", 32'(lat), 32'(SCAN_LAT));
    check("t1_count_const", 32'(count), 32'd2);
    check_results("t1");
    rd_slot = 4'd1; #1;
    check("t1_s1_idx_const", 32'(rd_idx), 32'd5);
    check("t1_s1_x_const", 32'(rd_x), 32'd20);
    rd_slot = 4'd0;
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(done), 32'd0);

    // Buffer overflow: twelve hits, ten kept
    set_all(8'd0);
    for (int i = 0; i < 12; i++) obj_y[i] = 8'd40;
    load_ram();
    model(8'd30, 1'b0);
    run_scan(8'd30, 1'b0, lat);
    check("t2_lat", 32'(lat), 32'(SCAN_LAT));
    check("t2_count_const", 32'(count), 32'd10);
    check_results("t2");

    // Height boundary around Y=10
    set_all(8'd200);
    obj_y[0] = 8'd10;
    load_ram();
    for (int k = 0; k < 3; k++) begin
      l = (k == 2) ? 8'd10 : 8'd9;
      t = (k != 0);
      model(l, t);
      run_scan(l, t, lat);
      check($sformatf("t3_%0d_lat", k), 32'(lat), 32'(SCAN_LAT));
      check($sformatf("t3_%0d_count_const", k), 32'(count), (k == 1) ? 32'd1 : 32'd0);
      check_results($sformatf("t3_%0d", k));
    end

    // Wraparound of the distance
    set_all(8'd0);
    obj_y[0] = 8'd160; obj_y[1] = 8'd159; obj_y[2] = 8'd200;
    load_ram();
    model(8'd143, 1'b0);
    run_scan(8'd143, 1'b0, lat);
    check("t4a_count_const", 32'(count), 32'd1);
    check_results("t4a");
    model(8'd0, 1'b0);
    run_scan(8'd0, 1'b0, lat);
    check("t4b_count_const", 32'(count), 32'd0);
    check_results("t4b");

    // Reset mid-scan, no done afterwards
    setup_t1();
    ly_i = 8'd0; tall_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_ceb", 32'(oam_ceb), 32'd0);
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("t5_no_done", 32'(seen), 32'd0);
    // Restart; a second start 20 clocks in must be ignored
    model(8'd0, 1'b0);
    ly_i = 8'd0; tall_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    repeat (19) begin @(posedge clk); #1; n++; end
    ly_i = 8'd30; tall_i = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    while (!done && n < 300) begin @(posedge clk); #1; n++; end
    check("t5_lat", 32'(done ? n : -1), 32'(SCAN_LAT));
    check_results("t5");

    // X ordering of three hits
    set_all(8'd0);
    obj_y[3] = 8'd60; obj_x[3] = 8'd50;
    obj_y[7] = 8'd60; obj_x[7] = 8'd20;
    obj_y[9] = 8'd60; obj_x[9] = 8'd20;
    load_ram();
    model(8'd50, 1'b0);
    run_scan(8'd50, 1'b0, lat);
    check_results("t6");
    for (int s = 0; s < 3; s++) begin
      rd_slot = 4'(s); #1;
`ifdef OAM_SCAN_SORT_EN
      check($sformatf("t6_const%0d", s), 32'(rd_idx), (s == 0) ? 32'd7 : (s == 1) ? 32'd9 : 32'd3);
`else
      check($sformatf("t6_const%0d", s), 32'(rd_idx), (s == 0) ? 32'd3 : (s == 1) ? 32'd7 : 32'd9);
`endif
    end
    rd_slot = 4'd0;

    // Random lines; odd iterations restart in the done cycle of a preceding scan
    for (int it = 0; it < 8; it++) begin
      l = 8'($urandom);
      t = 1'($urandom);
      for (int i = 0; i < NOBJ; i++) begin
        obj_x[i] = 8'($urandom);
        obj_y[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                               : 8'(int'(l) + 16 - int'($urandom_range(0, 20)));
      end
      load_ram();
      if (it % 2 == 1) begin
        l2 = 8'($urandom);
        t2 = 1'($urandom);
        run_scan(l2, t2, lat);
        check($sformatf("r%0d_pre_lat", it), 32'(lat), 32'(SCAN_LAT));
      end
      model(l, t);
      run_scan(l, t, lat);
      check($sformatf("r%0d_lat", it), 32'(lat), 32'(SCAN_LAT));
      check_results($sformatf("r%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
